// File: rtl/gmii_rx_client_pkg.sv
// Shared constants and types for the GMII receive client: the preamble and
// start-of-frame delimiter octets and the receive state encoding.
package gmii_rx_client_pkg;

  localparam logic [7:0] PREAMBLE_OCTET = 8'h55;
  localparam logic [7:0] SFD_OCTET      = 8'hD5;

  // Receive framing states; the encoding is fixed so that state dumps line up
  // with the transmit-side documentation.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

endpackage

// File: rtl/gmii_rx_client_if.sv
// Data-plane bundle of the GMII receive client: the PCS receive inputs on one
// side and the delimited payload stream with its length report on the other.
interface gmii_rx_client_if #(
  parameter int OCTET_WIDTH = 8,
  parameter int LEN_WIDTH   = 11
);

  // PCS receive side
  logic [OCTET_WIDTH-1:0] rxd;
  logic                   rx_dv;
  logic                   rx_er;

  // Payload stream towards the MAC-side logic
  logic [OCTET_WIDTH-1:0] out_data;
  logic                   out_valid;
  logic                   out_sof;
  logic                   out_eof;
  logic                   out_err;
  logic [LEN_WIDTH-1:0]   frame_len;
  logic                   frame_len_valid;

  // The PCS (or a bench standing in for it) drives the receive octets.
  modport master (
    output rxd, rx_dv, rx_er,
    input  out_data, out_valid, out_sof, out_eof, out_err,
    input  frame_len, frame_len_valid
  );

  // The client consumes the octets and produces the payload stream.
  modport slave (
    input  rxd, rx_dv, rx_er,
    output out_data, out_valid, out_sof, out_eof, out_err,
    output frame_len, frame_len_valid
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping, so a long-running
// link never reports a misleadingly small frame count.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             mr_main_reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count one per inc pulse, holding once every bit is set.
  always_ff @(posedge clk or negedge mr_main_reset_n) begin
    if (!mr_main_reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      // NOTE: sequential state is always updated with <= so every flop samples
      // the pre-edge values and simulation matches the synthesized netlist.
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/gmii_rx_client.sv
// GMII receive client: strips preamble/SFD, delimits frames on rx_dv, streams
// the payload through a one-octet hold register so the last octet can carry
// the end-of-frame marker, and keeps saturating good/bad frame counters.
module gmii_rx_client
  import gmii_rx_client_pkg::*;
#(
  parameter int OCTET_WIDTH = 8,
  parameter int LEN_WIDTH   = 11,
  parameter int MAX_FRAME   = 1518,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 mr_main_reset_n,
  gmii_rx_client_if.slave      bus,
  output logic [CNT_WIDTH-1:0] good_frames,
  output logic [CNT_WIDTH-1:0] bad_frames,
  output logic                 busy
);

  localparam logic [OCTET_WIDTH-1:0] PRE_OCTET = OCTET_WIDTH'(PREAMBLE_OCTET);
  localparam logic [OCTET_WIDTH-1:0] SOF_OCTET = OCTET_WIDTH'(SFD_OCTET);
  localparam logic [LEN_WIDTH-1:0]   MAX_LEN   = LEN_WIDTH'(MAX_FRAME);

  state_t                 state;
  logic [OCTET_WIDTH-1:0] hold;          // payload octet waiting for its successor
  logic                   hold_full;     // hold carries an octet not yet emitted
  logic                   first_pending; // next emitted octet opens the frame
  logic                   err_flag;      // rx_er seen during this frame's payload
  logic                   drop_bad;      // leaving DROP must count a bad frame
  logic [LEN_WIDTH-1:0]   count;         // payload octets accepted so far
  logic                   good_inc;
  logic                   bad_inc;

  // Framing FSM with registered stream outputs and counter increment pulses.
  always_ff @(posedge clk or negedge mr_main_reset_n) begin
    if (!mr_main_reset_n) begin
      state               <= IDLE;
      hold                <= '0;
      hold_full           <= 1'b0;
      first_pending       <= 1'b0;
      err_flag            <= 1'b0;
      drop_bad            <= 1'b0;
      count               <= '0;
      good_inc            <= 1'b0;
      bad_inc             <= 1'b0;
      bus.out_data        <= '0;
      bus.out_valid       <= 1'b0;
      bus.out_sof         <= 1'b0;
      bus.out_eof         <= 1'b0;
      bus.out_err         <= 1'b0;
      bus.frame_len       <= '0;
      bus.frame_len_valid <= 1'b0;
    end else begin
      // NOTE: the markers default low on every edge so each one is a clean
      // single-cycle pulse; a branch only has to raise the ones it needs.
      bus.out_valid       <= 1'b0;
      bus.out_sof         <= 1'b0;
      bus.out_eof         <= 1'b0;
      bus.out_err         <= 1'b0;
      bus.frame_len_valid <= 1'b0;
      good_inc            <= 1'b0;
      bad_inc             <= 1'b0;

      case (state)
        IDLE: begin
          // rx_er without rx_dv is false carrier or extension: ignored here.
          if (bus.rx_dv) begin
            if (bus.rx_er) begin
              state    <= DROP;
              drop_bad <= 1'b1;
            end else if (bus.rxd == PRE_OCTET) begin
              state <= PREAMBLE;
            end else if (bus.rxd == SOF_OCTET) begin
              // A shortened or missing preamble is accepted.
              state         <= DATA;
              hold_full     <= 1'b0;
              first_pending <= 1'b1;
              err_flag      <= 1'b0;
              count         <= '0;
            end else begin
              state    <= DROP;
              drop_bad <= 1'b1;
            end
          end
        end

        PREAMBLE: begin
          if (!bus.rx_dv) begin
            // Carrier ended inside the preamble: nothing to deliver.
            state   <= IDLE;
            bad_inc <= 1'b1;
          end else if (bus.rx_er) begin
            state    <= DROP;
            drop_bad <= 1'b1;
          end else if (bus.rxd == SOF_OCTET) begin
            state         <= DATA;
            hold_full     <= 1'b0;
            first_pending <= 1'b1;
            err_flag      <= 1'b0;
            count         <= '0;
          end else if (bus.rxd != PRE_OCTET) begin
            state    <= DROP;
            drop_bad <= 1'b1;
          end
        end

        DATA: begin
          if (bus.rx_dv) begin
            if (count == MAX_LEN) begin
              // Oversize: close the frame on the octet already held, count it
              // as bad now, and swallow the rest of the carrier.
              bus.out_data        <= hold;
              bus.out_valid       <= 1'b1;
              bus.out_sof         <= first_pending;
              bus.out_eof         <= 1'b1;
              bus.out_err         <= 1'b1;
              bus.frame_len       <= count;
              bus.frame_len_valid <= 1'b1;
              bad_inc             <= 1'b1;
              first_pending       <= 1'b0;
              hold_full           <= 1'b0;
              drop_bad            <= 1'b0;
              state               <= DROP;
            end else begin
              // The previous octet can only leave once we know it is not last.
              if (hold_full) begin
                bus.out_data  <= hold;
                bus.out_valid <= 1'b1;
                bus.out_sof   <= first_pending;
                first_pending <= 1'b0;
              end
              hold      <= bus.rxd;
              hold_full <= 1'b1;
              count     <= count + LEN_WIDTH'(1);
              if (bus.rx_er) begin
                err_flag <= 1'b1;
              end
            end
          end else begin
            if (hold_full) begin
              bus.out_data        <= hold;
              bus.out_valid       <= 1'b1;
              bus.out_sof         <= first_pending;
              bus.out_eof         <= 1'b1;
              bus.out_err         <= err_flag;
              bus.frame_len       <= count;
              bus.frame_len_valid <= 1'b1;
              good_inc            <= !err_flag;
              bad_inc             <= err_flag;
            end else begin
              // SFD followed directly by end of carrier: empty, hence bad.
              bad_inc <= 1'b1;
            end
            first_pending <= 1'b0;
            hold_full     <= 1'b0;
            state         <= IDLE;
          end
        end

        DROP: begin
          if (!bus.rx_dv) begin
            bad_inc  <= drop_bad;
            drop_bad <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Anything other than IDLE means a carrier event is being tracked.
  assign busy = (state != IDLE);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_good_cnt (
    .clk             (clk),
    .mr_main_reset_n (mr_main_reset_n),
    .inc             (good_inc),
    .count           (good_frames)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_bad_cnt (
    .clk             (clk),
    .mr_main_reset_n (mr_main_reset_n),
    .inc             (bad_inc),
    .count           (bad_frames)
  );

endmodule

// File: tb/tb_gmii_rx_client.sv
// Bench for gmii_rx_client: directed and random carrier bursts checked against
// a frame-level reference model that parses each burst from the framing rules.
module tb_gmii_rx_client;

  localparam int OW      = 8;
  localparam int LW      = 11;
  localparam int MF      = 1518;
  localparam int CW      = 4;    // narrow counters so saturation is reachable
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic          v;
    logic          sof;
    logic          eof;
    logic          err;
    logic          flv;
    logic [OW-1:0] d;
    logic [LW-1:0] len;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] good_frames;
  logic [CW-1:0] bad_frames;
  logic          busy;

  gmii_rx_client_if #(.OCTET_WIDTH(OW), .LEN_WIDTH(LW)) bus ();

  gmii_rx_client #(
    .OCTET_WIDTH (OW),
    .LEN_WIDTH   (LW),
    .MAX_FRAME   (MF),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk             (clk),
    .mr_main_reset_n (rst_n),
    .bus             (bus),
    .good_frames     (good_frames),
    .bad_frames      (bad_frames),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  ev_t         exp_q[$];
  ev_t         obs_q[$];
  logic [7:0]  tx_d[$];
  bit          tx_e[$];
  int          exp_good;
  int          exp_bad;
  ev_t         mon_e;

  // Capture every cycle that shows any stream marker, away from the edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.out_valid || bus.out_sof || bus.out_eof ||
                           bus.out_err || bus.frame_len_valid)) begin
      mon_e     = '0;
      mon_e.v   = bus.out_valid;
      mon_e.sof = bus.out_sof;
      mon_e.eof = bus.out_eof;
      mon_e.err = bus.out_err;
      mon_e.flv = bus.frame_len_valid;
      mon_e.d   = bus.out_data;
      mon_e.len = bus.frame_len_valid ? bus.frame_len : '0;
      obs_q.push_back(mon_e);
    end
  end

  // ---------------- reference model ----------------
  task automatic bump_good();
    if (exp_good < CNT_MAX) exp_good++;
  endtask

  task automatic bump_bad();
    if (exp_bad < CNT_MAX) exp_bad++;
  endtask

  // One rx_dv burst: 0x55s, then SFD, then payload. Any deviation or rx_er
  // before the payload discards it as bad; an empty payload is bad; beyond
  // MF octets the first MF are delivered with an error end.
  task automatic model_burst();
    int  n, i, plen, emit;
    bit  err;
    ev_t e;
    n = tx_d.size();
    i = 0;
    if (n == 0) return;
    while (i < n && tx_d[i] == 8'h55 && !tx_e[i]) i++;
    if (i >= n || tx_d[i] != 8'hD5 || tx_e[i]) begin
      bump_bad();
      return;
    end
    plen = n - i - 1;
    if (plen == 0) begin
      bump_bad();
      return;
    end
    emit = (plen > MF) ? MF : plen;
    err  = (plen > MF);
    for (int k = 0; k < emit; k++) begin
      if (tx_e[i + 1 + k]) err = 1'b1;
      e     = '0;
      e.v   = 1'b1;
      e.sof = (k == 0);
      e.d   = tx_d[i + 1 + k];
      if (k == emit - 1) begin
        e.eof = 1'b1;
        e.err = err;
        e.flv = 1'b1;
        e.len = LW'(emit);
      end
      exp_q.push_back(e);
    end
    if (err) bump_bad();
    else     bump_good();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic push_octet(input logic [7:0] d, input bit e);
    tx_d.push_back(d);
    tx_e.push_back(e);
  endtask

  task automatic clear_tx();
    tx_d.delete();
    tx_e.delete();
  endtask

  task automatic do_reset();
    bus.rx_dv = 1'b0;
    bus.rx_er = 1'b0;
    bus.rxd   = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    exp_good = 0;
    exp_bad  = 0;
  endtask

  task automatic send_burst(input int gap);
    model_burst();
    for (int i = 0; i < tx_d.size(); i++) begin
      @(negedge clk);
      bus.rx_dv = 1'b1;
      bus.rxd   = tx_d[i];
      bus.rx_er = tx_e[i];
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.rx_dv = 1'b0;
      bus.rxd   = 8'($urandom);
      bus.rx_er = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic settle();
    bus.rx_dv = 1'b0;
    bus.rx_er = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.rx_dv = 1'b0;
    bus.rx_er = 1'b0;
    bus.rxd   = '0;
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({bus.out_data, bus.out_valid, bus.out_sof, bus.out_eof, bus.out_err,
         bus.frame_len, bus.frame_len_valid, good_frames, bad_frames, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h v=%b sof=%b eof=%b err=%b len=%0d flv=%b good=%0d bad=%0d busy=%b want all 0",
               bus.out_data, bus.out_valid, bus.out_sof, bus.out_eof, bus.out_err,
               bus.frame_len, bus.frame_len_valid, good_frames, bad_frames, busy);
    end
    do_reset();
  endtask

  task automatic test_long_preamble();
    do_reset();
    clear_tx();
    repeat (7) push_octet(8'h55, 1'b0);
    push_octet(8'hD5, 1'b0);
    for (int k = 1; k <= 64; k++) push_octet(8'(k), 1'b0);
    send_burst(2);
    settle();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL long_frame_events: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL long_frame_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (good_frames !== CW'(1) || bad_frames !== CW'(0)) begin
      miscompares++;
      $display("FAIL long_frame_counters: got good=%0d bad=%0d want good=1 bad=0", good_frames, bad_frames);
    end
  endtask

  task automatic test_single_octet();
    do_reset();
    clear_tx();
    push_octet(8'hD5, 1'b0);
    push_octet(8'hAA, 1'b0);
    send_burst(2);
    settle();
    vectors++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      miscompares++;
      $display("FAIL single_octet_events: got %0d want 1", obs_q.size());
    end else begin
      vectors++;
      if (obs_q[0] !== exp_q[0]) begin
        miscompares++;
        $display("FAIL single_octet_ev: got %h want %h", obs_q[0], exp_q[0]);
      end
    end
    vectors++;
    if (good_frames !== CW'(1) || bad_frames !== CW'(0)) begin
      miscompares++;
      $display("FAIL single_octet_counters: got good=%0d bad=%0d want good=1 bad=0", good_frames, bad_frames);
    end
  endtask

  task automatic test_rx_er();
    do_reset();
    clear_tx();
    repeat (7) push_octet(8'h55, 1'b0);
    push_octet(8'hD5, 1'b0);
    for (int k = 1; k <= 64; k++) push_octet(8'($urandom), k == 10);
    send_burst(2);
    settle();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rx_er_events: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rx_er_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (good_frames !== CW'(0) || bad_frames !== CW'(1)) begin
      miscompares++;
      $display("FAIL rx_er_counters: got good=%0d bad=%0d want good=0 bad=1", good_frames, bad_frames);
    end
  endtask

  task automatic test_bad_preamble();
    do_reset();
    clear_tx();
    push_octet(8'h55, 1'b0);
    push_octet(8'h55, 1'b0);
    push_octet(8'h12, 1'b0);
    repeat (20) push_octet(8'($urandom), 1'b0);
    model_burst();
    for (int i = 0; i < tx_d.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL bad_preamble_busy%0d: got %b want 1", i, busy);
        end
      end
      bus.rx_dv = 1'b1;
      bus.rxd   = tx_d[i];
      bus.rx_er = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_preamble_busy_last: got %b want 1", busy);
    end
    bus.rx_dv = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_preamble_busy_end: got %b want 0", busy);
    end
    settle();
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL bad_preamble_events: got %0d want 0", obs_q.size());
    end
    vectors++;
    if (good_frames !== CW'(0) || bad_frames !== CW'(1)) begin
      miscompares++;
      $display("FAIL bad_preamble_counters: got good=%0d bad=%0d want good=0 bad=1", good_frames, bad_frames);
    end
  endtask

  task automatic test_zero_payload();
    do_reset();
    clear_tx();
    push_octet(8'h55, 1'b0);
    push_octet(8'h55, 1'b0);
    push_octet(8'hD5, 1'b0);
    send_burst(2);
    settle();
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL zero_payload_events: got %0d want 0", obs_q.size());
    end
    vectors++;
    if (good_frames !== CW'(0) || bad_frames !== CW'(1)) begin
      miscompares++;
      $display("FAIL zero_payload_counters: got good=%0d bad=%0d want good=0 bad=1", good_frames, bad_frames);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    clear_tx();
    repeat (7) push_octet(8'h55, 1'b0);
    push_octet(8'hD5, 1'b0);
    repeat (1600) push_octet(8'($urandom), 1'b0);
    send_burst(2);
    settle();
    vectors++;
    if (obs_q.size() != MF || exp_q.size() != MF) begin
      miscompares++;
      $display("FAIL oversize_events: got %0d want %0d", obs_q.size(), MF);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL oversize_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (good_frames !== CW'(0) || bad_frames !== CW'(1)) begin
      miscompares++;
      $display("FAIL oversize_counters: got good=%0d bad=%0d want good=0 bad=1", good_frames, bad_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    clear_tx();
    repeat (7) push_octet(8'h55, 1'b0);
    push_octet(8'hD5, 1'b0);
    repeat (60) push_octet(8'($urandom), 1'b0);
    for (int i = 0; i < 8 + 30; i++) begin
      @(negedge clk);
      bus.rx_dv = 1'b1;
      bus.rxd   = tx_d[i];
      bus.rx_er = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    obs_q.delete();
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if ({bus.out_data, bus.out_valid, bus.out_sof, bus.out_eof, bus.out_err,
           bus.frame_len, bus.frame_len_valid, good_frames, bad_frames, busy} !== '0) begin
        miscompares++;
        $display("FAIL mid_reset_outputs%0d: got v=%b eof=%b len=%0d good=%0d bad=%0d busy=%b want all 0",
                 c, bus.out_valid, bus.out_eof, bus.frame_len, good_frames, bad_frames, busy);
      end
      @(negedge clk);
      bus.rxd = 8'($urandom);
    end
    bus.rx_dv = 1'b0;
    #3;
    rst_n = 1'b1;
    exp_q.delete();
    exp_good = 0;
    exp_bad  = 0;
    settle();
    vectors++;
    if (obs_q.size() != 0 || good_frames !== CW'(0) || bad_frames !== CW'(0)) begin
      miscompares++;
      $display("FAIL mid_reset_aborted: got events=%0d good=%0d bad=%0d want 0 0 0",
               obs_q.size(), good_frames, bad_frames);
    end
    clear_tx();
    repeat (7) push_octet(8'h55, 1'b0);
    push_octet(8'hD5, 1'b0);
    repeat (46) push_octet(8'($urandom), 1'b0);
    send_burst(2);
    settle();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL mid_reset_events: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL mid_reset_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (good_frames !== CW'(1) || bad_frames !== CW'(0)) begin
      miscompares++;
      $display("FAIL mid_reset_counters: got good=%0d bad=%0d want good=1 bad=0", good_frames, bad_frames);
    end
  endtask

  task automatic test_back_to_back();
    int pre_len, plen, idx;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      clear_tx();
      pre_len = $urandom_range(0, 7);
      repeat (pre_len) push_octet(8'h55, 1'b0);
      push_octet(8'hD5, 1'b0);
      plen = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 60);
      repeat (plen) push_octet(8'($urandom), $urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, pre_len);
        tx_d[idx] = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) tx_e[$urandom_range(0, pre_len)] = 1'b1;
      send_burst($urandom_range(1, 3));
    end
    settle();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL random_events: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random_ev%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (good_frames !== CW'(exp_good) || bad_frames !== CW'(exp_bad)) begin
      miscompares++;
      $display("FAIL random_counters: got good=%0d bad=%0d want good=%0d bad=%0d",
               good_frames, bad_frames, exp_good, exp_bad);
    end
  endtask

  initial begin
    test_reset();
    test_long_preamble();
    test_single_octet();
    test_rx_er();
    test_bad_preamble();
    test_zero_payload();
    test_oversize();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
